demux_serializer: RTL

- Parametrised successor of the word-to-byte channel demultiplexer, running in a single clock domain.
- Accepts MST_DWIDTH-bit words through a valid/ready handshake and routes each word to one of NUM_CH output channels.
- On the chosen channel, the word is sent as MST_DWIDTH/SYS_DWIDTH consecutive SYS_DWIDTH-bit chunks.
- Each channel has its own valid/ready handshake for backpressure. Words can be accepted back-to-back with no bubble. Chunk order and invalid-select handling are defined below.

---
 rtl/demux_serializer.sv | 105 ++++++++++
 1 files changed

// File: rtl/demux_serializer.sv
// Word-to-chunk channel demultiplexer: accepts one wide word, routes it to a selected
// channel and streams it out as RATIO narrow chunks under per-channel valid/ready.
module demux_serializer #(
  parameter int unsigned MST_DWIDTH = 32,
  parameter int unsigned SYS_DWIDTH = 8,
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned SEL_WIDTH  = 2,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                         clk_sys,
  input  logic                         rst_n,
  input  logic [SEL_WIDTH-1:0]         select_i,
  input  logic [MST_DWIDTH-1:0]        data_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [NUM_CH*SYS_DWIDTH-1:0] data_o,
  output logic [NUM_CH-1:0]            valid_o,
  input  logic [NUM_CH-1:0]            ready_i,
  output logic                         err_o
);

  localparam int unsigned RATIO = MST_DWIDTH / SYS_DWIDTH;
  localparam int unsigned CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  if (MST_DWIDTH % SYS_DWIDTH != 0) begin : g_bad_ratio
    $fatal(1, "MST_DWIDTH must be a multiple of SYS_DWIDTH");
  end
  if (NUM_CH > 2 ** SEL_WIDTH) begin : g_bad_num_ch
    $fatal(1, "NUM_CH exceeds the range of select_i");
  end

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e                       r_state, w_state_d;
  logic [SEL_WIDTH-1:0]         r_ch, w_ch_d;
  logic [CNT_W-1:0]             r_cnt, w_cnt_d;
  logic [MST_DWIDTH-1:0]        r_word, w_word_d;
  logic [NUM_CH*SYS_DWIDTH-1:0] r_hold, w_hold_d;
  logic                         r_err, w_err_d;

  logic                  w_sel_ok, w_xfer, w_last, w_accept;
  logic [SYS_DWIDTH-1:0] w_chunk;

  // The current chunk always sits at the outgoing end of the shift register.
  assign w_chunk  = MSB_FIRST ? r_word[MST_DWIDTH-1 -: SYS_DWIDTH] : r_word[SYS_DWIDTH-1:0];
  assign w_sel_ok = {1'b0, select_i} < (SEL_WIDTH + 1)'(NUM_CH);
  assign w_xfer   = (r_state == StSend) && ready_i[r_ch];
  assign w_last   = (r_cnt == LAST_CNT);
  assign ready_o  = (r_state == StIdle) || (w_last && w_xfer);
  assign w_accept = valid_i && ready_o;
  assign err_o    = r_err;

  always_comb begin
    w_state_d = r_state;
    w_ch_d    = r_ch;
    w_cnt_d   = r_cnt;
    w_word_d  = r_word;
    w_hold_d  = r_hold;
    w_err_d   = w_accept && !w_sel_ok;
    if (w_xfer) begin
      w_hold_d[r_ch*SYS_DWIDTH +: SYS_DWIDTH] = w_chunk;
      w_cnt_d  = r_cnt + CNT_W'(1);
      w_word_d = MSB_FIRST ? (r_word << SYS_DWIDTH) : (r_word >> SYS_DWIDTH);
      if (w_last) begin
        w_state_d = StIdle;
      end
    end
    // A valid accept overrides the completion of the previous word (no bubble).
    if (w_accept && w_sel_ok) begin
      w_state_d = StSend;
      w_ch_d    = select_i;
      w_cnt_d   = '0;
      w_word_d  = data_i;
    end
  end

  always_comb begin
    valid_o = '0;
    data_o  = r_hold;
    if (r_state == StSend) begin
      valid_o[r_ch]                         = 1'b1;
      data_o[r_ch*SYS_DWIDTH +: SYS_DWIDTH] = w_chunk;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_ch    <= '0;
      r_cnt   <= '0;
      r_word  <= '0;
      r_hold  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_ch    <= w_ch_d;
      r_cnt   <= w_cnt_d;
      r_word  <= w_word_d;
      r_hold  <= w_hold_d;
      r_err   <= w_err_d;
    end
  end

endmodule
